matrix_maxpool: RTL
===================

Name: matrix_maxpool

Overview:
Post-processing stage that runs after the convolution engine finishes. It reads the convolution result matrix from shared RAM, applies POOL x POOL max-pooling with stride POOL and optional ReLU, and writes the pooled matrix back to RAM. It uses the same word-addressed memory handshake as the convolution engine. The sequencer starts it by raising enable after the convolution's done.

Parameters:
POOL, 2, window edge and stride; legal values 2..4.
RELU, 1, 1 = clamp negative maxima to 0 before writing; 0 = write raw maxima.
PARAM_BASE, 32'h0000_0010, word address of the 4-word parameter block.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  run enable; low freezes the FSM and holds all outputs.
mem_opdone  input  1  memory completed the current read/write; data_i valid on reads.
data_i  input  32  read data, signed two's complement.
data_o  output  32  write data.
addr_o  output  32  word address.
mem_operation  output  2  01 read, 11 write, 00 none.
done  output  1  high when the job is complete.

Behaviour:
- Reset (async, reset=0): data_o=0, addr_o=0, mem_operation=00, done=0, state=IDLE, all counters and buffers 0.
- Parameter block, read in this order: PARAM_BASE+0 width W, +1 height H, +2 source base SRC, +3 destination base DST.
- Output size: OW=W/POOL, OH=H/POOL, integer floor. Trailing rows and columns are ignored.
- Element addresses: in[r][c] at SRC + r*W + c. out[y][x] at DST + y*OW + x. All address arithmetic is 32-bit and wraps modulo 2^32.
- Memory transaction rules:
  - The FSM drives mem_operation and addr_o (and data_o for writes) on one edge, then holds them until it samples mem_opdone=1.
  - The same edge that samples mem_opdone=1 captures data_i and drives mem_operation=00.
  - There is at least one 00 cycle between consecutive transactions.
  - mem_opdone is ignored while mem_operation=00.
- States:
  - IDLE: leaves to FETCH_PARAMS when enable=1. Clears counters, done=0.
  - FETCH_PARAMS: 4 reads in order. If OW=0 or OH=0, goes to DONE with no writes; otherwise y=x=0 and goes to WIN_INIT.
  - WIN_INIT: wr=wc=0, first_flag=1, goes to READ.
  - READ: reads in[y*POOL+wr][x*POOL+wc], goes to CMP.
  - CMP:
    - max = sample when first_flag=1; otherwise max = sample if sample > max (signed compare). first_flag is then cleared.
    - Scans wc first, then wr. Returns to READ until POOL*POOL samples are done, then goes to WRITE.
  - WRITE:
    - data_o = (RELU && max<0) ? 0 : max, written to out[y][x].
    - Then advances x; at OW it wraps x=0 and advances y.
    - Goes to DONE when y reaches OH, else to WIN_INIT.
  - DONE: done=1, mem_operation=00. Holds until enable=0, then done=0 and returns to IDLE.
- Timing: each read or write takes at least 2 cycles (request plus opdone) plus 1 idle cycle. A window takes POOL*POOL reads, one CMP per read, and one write.
- enable low mid-job: the FSM stalls in its current state with outputs held. An outstanding transaction stays asserted, and mem_opdone arriving while enable=0 is not consumed. The job resumes when enable returns high.
- reset low at any point aborts immediately to reset values. There is no partial-result cleanup.
- Maxima are computed on full 32-bit signed values; no saturation is needed.

Test Plan:
- Basic pooling, POOL=2, RELU=0, W=H=4, SRC=0x40, DST=0x80, input rows {1,2,3,4}{5,6,7,8}{9,10,11,12}{13,14,15,16} -> exactly 4 writes: 0x80=6, 0x81=8, 0x82=14, 0x83=16; then done=1.
- ReLU path, RELU=1, W=H=2, all inputs negative {-5,-3,-9,-7} -> one write of 0 to DST. The same case with RELU=0 -> write 0xFFFF_FFFD (-3).
- Odd dimensions, W=5, H=3, POOL=2 -> OW=2, OH=1, 2 writes. Column 4 and row 2 are never read; check the address trace covers only c<4, r<2.
- Degenerate size, W=1, H=4 -> 4 parameter reads, zero writes, done=1.
- Handshake stress, random mem_opdone latency 1..7 cycles with enable toggled low mid-transaction -> outputs stable while stalled, one 00 cycle between transactions, results identical to the basic pooling case.
- Async reset asserted mid-WRITE, between edges -> outputs go to reset values immediately. A new enable rerun completes correctly.

Source files
------------

// File: rtl/matrix_maxpool.sv
// matrix_maxpool
//   Post-convolution stage: reads a W x H signed matrix from shared RAM,
//   applies POOL x POOL max-pooling with stride POOL (optional ReLU), and
//   writes the (W/POOL) x (H/POOL) result back through the same word
//   addressed read/write handshake used by the convolution engine.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   enable         run enable; low freezes the FSM and holds every output
//   mem_opdone     memory finished current transaction (data_i valid on reads)
//   data_i[31:0]   read data, signed
//   data_o[31:0]   write data
//   addr_o[31:0]   word address
//   mem_operation  01 read, 11 write, 00 idle
//   done           job complete
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | waiting for enable, counters cleared
// FETCH_PARAMS | reading W, H, SRC, DST from the parameter block
// WIN_INIT     | reset window row/column scan for output (y, x)
// READ         | fetch one window sample
// CMP          | fold sample into running maximum, advance scan
// WRITE        | store (optionally ReLU'd) maximum to out[y][x]
// DONE         | done=1 until enable drops
module matrix_maxpool #(
  parameter int          POOL       = 2,
  parameter int          RELU       = 1,
  parameter logic [31:0] PARAM_BASE = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_opdone,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] addr_o,
  output logic [1:0]  mem_operation,
  output logic        done
);

  localparam logic [31:0] POOL_W  = 32'(POOL);
  localparam logic [1:0]  POOL_M1 = 2'(POOL - 1);
  localparam logic [1:0]  OP_NONE = 2'b00;
  localparam logic [1:0]  OP_RD   = 2'b01;
  localparam logic [1:0]  OP_WR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, FETCH_PARAMS, WIN_INIT, READ, CMP, WRITE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_o_q, data_o_d;
  logic [31:0] addr_o_q, addr_o_d;
  logic [1:0]  op_q, op_d;
  logic        done_q, done_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [31:0] w_q, w_d, h_q, h_d, src_q, src_d, dst_q, dst_d;
  logic [31:0] ow_q, ow_d, oh_q, oh_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [1:0]  wr_q, wr_d, wc_q, wc_d;
  logic        first_q, first_d;
  logic [31:0] sample_q, sample_d;
  logic [31:0] max_q, max_d;

  logic [31:0] in_row, in_col, in_addr, out_addr, wr_val;

  assign in_row   = y_q * POOL_W + {30'b0, wr_q};
  assign in_col   = x_q * POOL_W + {30'b0, wc_q};
  assign in_addr  = src_q + in_row * w_q + in_col;
  assign out_addr = dst_q + y_q * ow_q + x_q;
  assign wr_val   = ((RELU != 0) && max_q[31]) ? 32'h0 : max_q;

  always_comb begin
    state_d  = state_q;
    data_o_d = data_o_q;
    addr_o_d = addr_o_q;
    op_d     = op_q;
    done_d   = done_q;
    pidx_d   = pidx_q;
    w_d      = w_q;
    h_d      = h_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ow_d     = ow_q;
    oh_d     = oh_q;
    x_d      = x_q;
    y_d      = y_q;
    wr_d     = wr_q;
    wc_d     = wc_q;
    first_d  = first_q;
    sample_d = sample_q;
    max_d    = max_q;

    if (state_q == DONE) begin
      // DONE is the only state that reacts to enable being low.
      done_d = 1'b1;
      op_d   = OP_NONE;
      if (!enable) begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          done_d  = 1'b0;
          pidx_d  = 2'd0;
          x_d     = 32'd0;
          y_d     = 32'd0;
          wr_d    = 2'd0;
          wc_d    = 2'd0;
          first_d = 1'b0;
          state_d = FETCH_PARAMS;
        end
        FETCH_PARAMS: begin
          if (op_q == OP_NONE) begin
            op_d     = OP_RD;
            addr_o_d = PARAM_BASE + {30'b0, pidx_q};
          end else if (mem_opdone) begin
            op_d   = OP_NONE;
            pidx_d = pidx_q + 2'd1;
            case (pidx_q)
              2'd0:    w_d   = data_i;
              2'd1:    h_d   = data_i;
              2'd2:    src_d = data_i;
              default: dst_d = data_i;
            endcase
            if (pidx_q == 2'd3) begin
              ow_d = w_q / POOL_W;
              oh_d = h_q / POOL_W;
              x_d  = 32'd0;
              y_d  = 32'd0;
              if (ow_d == 32'd0 || oh_d == 32'd0) begin
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                state_d = WIN_INIT;
              end
            end
          end
        end
        WIN_INIT: begin
          wr_d    = 2'd0;
          wc_d    = 2'd0;
          first_d = 1'b1;
          state_d = READ;
        end
        READ: begin
          if (op_q == OP_NONE) begin
            op_d     = OP_RD;
            addr_o_d = in_addr;
          end else if (mem_opdone) begin
            op_d     = OP_NONE;
            sample_d = data_i;
            state_d  = CMP;
          end
        end
        CMP: begin
          if (first_q || ($signed(sample_q) > $signed(max_q)))
            max_d = sample_q;
          first_d = 1'b0;
          state_d = READ;
          if (wc_q == POOL_M1) begin
            wc_d = 2'd0;
            if (wr_q == POOL_M1) state_d = WRITE;
            else                 wr_d    = wr_q + 2'd1;
          end else begin
            wc_d = wc_q + 2'd1;
          end
        end
        WRITE: begin
          if (op_q == OP_NONE) begin
            op_d     = OP_WR;
            addr_o_d = out_addr;
            data_o_d = wr_val;
          end else if (mem_opdone) begin
            op_d    = OP_NONE;
            state_d = WIN_INIT;
            if (x_q + 32'd1 == ow_q) begin
              x_d = 32'd0;
              y_d = y_q + 32'd1;
              if (y_q + 32'd1 == oh_q) begin
                done_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              x_d = x_q + 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_o_q <= '0;
      addr_o_q <= '0;
      op_q     <= OP_NONE;
      done_q   <= 1'b0;
      pidx_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      ow_q     <= '0;
      oh_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      wr_q     <= '0;
      wc_q     <= '0;
      first_q  <= 1'b0;
      sample_q <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_o_q <= data_o_d;
      addr_o_q <= addr_o_d;
      op_q     <= op_d;
      done_q   <= done_d;
      pidx_q   <= pidx_d;
      w_q      <= w_d;
      h_q      <= h_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      ow_q     <= ow_d;
      oh_q     <= oh_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wr_q     <= wr_d;
      wc_q     <= wc_d;
      first_q  <= first_d;
      sample_q <= sample_d;
      max_q    <= max_d;
    end
  end

  assign data_o        = data_o_q;
  assign addr_o        = addr_o_q;
  assign mem_operation = op_q;
  assign done          = done_q;

endmodule
